// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: mode records, legal
// divider/latency ranges and line/frame total helper.
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } mode_t;

  localparam mode_t MODE_640X480 = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33}
  };

  localparam mode_t MODE_800X600 = '{
    h: '{800, 40, 128, 88},
    v: '{600, 1, 4, 23}
  };

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 4;
  localparam int CLK_DIV_MAX = 4;

  function automatic bit div_legal(int d);
    return (d == 1) || (d == 2) || (d == CLK_DIV_MAX);
  endfunction

  function automatic int line_total(
    int sync, int bp, int active, int fp
  );
    return sync + bp + active + fp;
  endfunction

endpackage

// File: rtl/vga_timing_param_if.sv
// Pixel-RAM and connector bundle of the VGA timing
// generator.
interface vga_timing_param_if #(
  parameter int CW = 4
);

  logic [3*CW-1:0] din;
  logic [9:0]      pcol;
  logic [9:0]      prow;
  logic            rdn;
  logic [CW-1:0]   r;
  logic [CW-1:0]   g;
  logic [CW-1:0]   b;
  logic            hs;
  logic            vs;
  logic            de;
  logic            pix_ce;
  logic            frame_start;

  modport master (
    input  din,
    output pcol, prow, rdn,
    output r, g, b, hs, vs, de,
    output pix_ce, frame_start
  );

  modport slave (
    output din,
    input  pcol, prow, rdn,
    input  r, g, b, hs, vs, de,
    input  pix_ce, frame_start
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider, h/v raster counters and raw
// sync/active decode.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_ce,
  output logic [10:0] h,
  output logic [10:0] v,
  output logic        hs_raw,
  output logic        vs_raw,
  output logic        active
);

  localparam int H_TOTAL =
    line_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL =
    line_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_PULSE = 11'(H_SYNC);
  localparam logic [10:0] V_PULSE = 11'(V_SYNC);
  localparam logic [10:0] H_BEG = 11'(H_SYNC + H_BP);
  localparam logic [10:0] V_BEG = 11'(V_SYNC + V_BP);
  localparam logic [10:0] H_END =
    11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_END =
    11'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 2'd1;
    end
  end

  assign pix_ce = (div == DIV_LAST);

  // Frame wrap rides on the same tick as the line wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 11'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  assign hs_raw = (h < H_PULSE);
  assign vs_raw = (v < V_PULSE);
  assign active = (h >= H_BEG) && (h < H_END) &&
                  (v >= V_BEG) && (v < V_END);

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with pixel-RAM read
// and sync/colour realignment.
module vga_timing_param
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = MODE_640X480.h.active,
  parameter int H_FP     = MODE_640X480.h.fp,
  parameter int H_SYNC   = MODE_640X480.h.sync,
  parameter int H_BP     = MODE_640X480.h.bp,
  parameter int V_ACTIVE = MODE_640X480.v.active,
  parameter int V_FP     = MODE_640X480.v.fp,
  parameter int V_SYNC   = MODE_640X480.v.sync,
  parameter int V_BP     = MODE_640X480.v.bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int RD_LAT   = 1,
  parameter int CW       = 4
) (
  input logic                clk,
  input logic                rst,
  vga_timing_param_if.master vga
);

  if (!div_legal(CLK_DIV) ||
      RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX)
  begin : g_bad_param
    $error("vga_timing_param: illegal CLK_DIV/RD_LAT");
  end

  localparam logic [10:0] H_OFF = 11'(H_SYNC + H_BP);
  localparam logic [10:0] V_OFF = 11'(V_SYNC + V_BP);

  logic        pix_ce;
  logic [10:0] h;
  logic [10:0] v;
  logic        hs_raw;
  logic        vs_raw;
  logic        active;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .h      (h),
    .v      (v),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .active (active)
  );

  assign vga.pix_ce = pix_ce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.rdn         <= 1'b1;
      vga.pcol        <= '0;
      vga.prow        <= '0;
      vga.frame_start <= 1'b0;
    end else if (pix_ce) begin
      vga.rdn         <= ~active;
      vga.pcol        <= active ? 10'(h - H_OFF) : '0;
      vga.prow        <= active ? 10'(v - V_OFF) : '0;
      vga.frame_start <= (h == '0) && (v == '0);
    end
  end

  // {hs, vs, active} travel alongside the RAM read.
  logic [2:0] dly [RD_LAT];
  logic [2:0] late;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
    end else if (pix_ce) begin
      dly[0] <= {hs_raw, vs_raw, active};
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign late = dly[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.hs <= ~HS_POL;
      vga.vs <= ~VS_POL;
      vga.de <= 1'b0;
      vga.r  <= '0;
      vga.g  <= '0;
      vga.b  <= '0;
    end else if (pix_ce) begin
      vga.hs <= late[2] ^ ~HS_POL;
      vga.vs <= late[1] ^ ~VS_POL;
      vga.de <= late[0];
      vga.r  <= late[0] ? vga.din[CW-1:0] : '0;
      vga.g  <= late[0] ? vga.din[2*CW-1:CW] : '0;
      vga.b  <= late[0] ? vga.din[3*CW-1:2*CW] : '0;
    end
  end

endmodule
